// File: rtl/pipe_add_pkg.sv
// Shared definitions for the pipelined adder/subtractor: default geometry,
// stage payload layout and a reference overflow helper.
package pipe_add_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;
  localparam int CH         = DEF_WIDTH / DEF_STAGES;

  // Stage payload at the default geometry; the top declares the same layout
  // locally so that it tracks its own WIDTH parameter.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
    logic [DEF_WIDTH-1:0] s;
  } pipe_stage_t;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Signed overflow from the operand MSBs (b already conditionally inverted).
  function automatic logic ref_ovf(input logic a_msb, input logic b_eff_msb,
                                   input logic s_msb);
    return (a_msb == b_eff_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// Combinational CH-bit ripple chunk adder made of per-bit full-add cells.
module pipe_add_stage #(
  parameter int CH = 4
) (
  input  logic [CH-1:0] i_a,
  input  logic [CH-1:0] i_b,
  input  logic          i_cin,
  output logic [CH-1:0] o_sum,
  output logic          o_cout
);

  logic w_carry;

  always_comb begin
    w_carry = i_cin;
    o_sum   = '0;
    for (int i = 0; i < CH; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_carry;
  end

endmodule

// File: rtl/pipe_add.sv
// Pipelined ripple-carry adder/subtractor: one CH-bit chunk per stage, carry
// registered between stages, valid/ready handshake with bubble collapsing.
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t            w_cur [STAGES];
  stage_t            w_src [STAGES];
  logic [STAGES-1:0] w_load;

  // A stage loads when empty or when the stage after it is loading.
  always_comb begin
    w_load             = '0;
    w_load[STAGES-1]   = ~w_cur[STAGES-1].valid | out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_load[k] = ~w_cur[k].valid | w_load[k+1];
    end
  end

  assign in_ready = w_load[0];

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    stage_t           r_stage;
    stage_t           w_next;
    logic [CHUNK-1:0] w_chunk;
    logic             w_cout;

    if (gi == 0) begin : g_first
      assign w_src[gi] = '{valid: in_valid, carry: sub, a: a,
                           b: (sub ? ~b : b), s: '0};
    end else begin : g_rest
      assign w_src[gi] = w_cur[gi-1];
    end

    pipe_add_stage #(.CH(CHUNK)) u_stage (
      .i_a   (w_src[gi].a[gi*CHUNK +: CHUNK]),
      .i_b   (w_src[gi].b[gi*CHUNK +: CHUNK]),
      .i_cin (w_src[gi].carry),
      .o_sum (w_chunk),
      .o_cout(w_cout)
    );

    always_comb begin
      w_next                        = w_src[gi];
      w_next.carry                  = w_cout;
      w_next.s[gi*CHUNK +: CHUNK]   = w_chunk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_stage <= '0;
      end else if (w_load[gi]) begin
        if (w_src[gi].valid) begin
          r_stage <= w_next;
        end else begin
          r_stage.valid <= 1'b0;
        end
      end
    end

    assign w_cur[gi] = r_stage;
  end

  assign out_valid = w_cur[STAGES-1].valid;
  assign sum       = w_cur[STAGES-1].s;
  assign cout      = w_cur[STAGES-1].carry;
  assign ovf       = (w_cur[STAGES-1].a[WIDTH-1] == w_cur[STAGES-1].b[WIDTH-1]) &&
                     (w_cur[STAGES-1].s[WIDTH-1] != w_cur[STAGES-1].a[WIDTH-1]);

endmodule

// File: doc/pipe_add.md
Name: pipe_add

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor for the decoder datapath, e.g. path-metric and branch-metric arithmetic.
- Splits a WIDTH-bit operation into STAGES equal chunks, one chunk per clock stage, with the carry registered between stages.
- Adds subtract mode, carry/overflow flags and a valid/ready handshake with stall, none of which the single-bit full-add cell has.
- Throughput is one operation per clock when not stalled.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth = latency in cycles; 1 ≤ STAGES ≤ WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operands are valid this cycle.
- in_ready  out  1  block accepts the input this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0 selects A+B; 1 selects A−B.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH  result modulo 2^WIDTH.
- cout  out  1  carry out of the MSB; for subtract, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - Clock and reset are decided as: one clock `clk`; reset `rst_n` is asynchronous and active-low.
  - Asserting rst_n low clears all stage valid bits immediately: out_valid=0, sum=0, cout=0, ovf=0.
  - Any operations in flight are discarded and never appear at the output.
  - in_ready is 1 as soon as reset releases.
- Arithmetic:
  - Let CH = WIDTH/STAGES and B' = sub ? ~b : b.
  - Carry into chunk 0 equals sub.
  - Stage k (0..STAGES−1) adds bits [k*CH +: CH] of A and B' plus the registered carry from stage k−1.
  - Results are bit-exact to the single-cycle expression {cout,sum} = A + B' + sub.
  - ovf = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
- Operand skew:
  - On acceptance, stage 0 captures all of A, B', sub and produces chunk 0 of the result.
  - Each stage forwards the not-yet-used upper operand chunks and the completed lower result chunks with its valid bit.
  - Outputs are driven from the final stage registers; there is no combinational path from a/b to sum.
- Handshake:
  - A transfer occurs on a clock edge where valid && ready are both high.
  - Stage k loads when its valid is 0 or stage k+1 loads; the final stage counts as "loading" when out_ready=1.
  - in_ready = stage-0 load condition. It may depend on out_ready combinationally.
  - Latency is exactly STAGES cycles from input acceptance to out_valid, in an unstalled pipe.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
  - Payload is stable while out_valid=1 and out_ready=0.
- Boundaries:
  - Full pipe with out_ready=0 gives in_ready=0; inputs presented then are not accepted.
  - Simultaneous output drain and input accept in the same cycle with a full pipe is allowed, giving 1 op/cycle.
  - When sub changes between consecutive inputs, each operation uses its own captured sub.
  - STAGES=1 degenerates to a single registered adder with latency 1.
  - Carry chains that ripple across every chunk (e.g. 0xFFFF+1) must be correct.

Decomposition:
- Shared package pipe_add_pkg:
  - localparam CH = WIDTH/STAGES;
  - a stage-payload struct typedef: valid, carry, remaining operand bits, completed result bits;
  - a function computing the reference ovf, for the bench.
- One natural sub-module: pipe_add_stage.
  - Combinational CH-bit ripple chunk adder built from per-bit full-add cells.
  - Instantiated once per stage.
  - The top module owns all registers and the stall logic.

Test Plan:
- Use WIDTH=16, STAGES=4 unless stated.
- Carry ripple: a=0xFFFF, b=0x0001, sub=0, out_ready=1 -> out_valid exactly 4 cycles later; sum=0x0000, cout=1, ovf=0.
- Signed overflow and subtract:
  - 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
  - 0x0005−0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000−0x0001 -> sum=0x7FFF, cout=1, ovf=1.
- Throughput: 8 back-to-back inputs a=i, b=0x0100*i with out_ready=1 -> 8 consecutive results on cycles 4..11, in order, in_ready held 1.
- Stall/backpressure: fill the pipe, drop out_ready for 6 cycles -> in_ready=0 after 4 accepts, head result held stable; release -> no loss or duplication, order preserved.
- Bubble collapse: inputs on cycles 0 and 3, out_ready=0 from cycle 2 -> both operations are resident and in_ready stays 1 until the pipe is full.
- Reset mid-operation: assert rst_n low with 3 ops in flight -> out_valid=0 immediately (asynchronous); after release no stale result appears; next op 0x1234+0x1111 -> 0x2345, 4 cycles later.
- Sweep: random a, b, sub, and random in_valid/out_ready at STAGES=1, 2, 4, 16 -> scoreboard matches A+B'+sub exactly.
